// File: rtl/gf_mul_serial_if.sv
// rtl/gf_mul_serial_if.sv - start/operand/result handshake bundle for the serial GF(2^M) multiplier
interface gf_mul_serial_if #(
    parameter int M = 6
);
    logic         start;
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic         busy;
    logic         done;
    logic [M-1:0] z;

    // Requester drives the operands, the multiplier returns status and product
    modport master (output start, output x, output y, input busy, input done, input z);
    modport slave  (input start, input x, input y, output busy, output done, output z);
endinterface

// File: rtl/gf_mul_serial.sv
// rtl/gf_mul_serial.sv - digit-serial GF(2^M) multiplier, MSB-first with interleaved reduction; optional zero bypass via GF_MUL_ZERO_BYPASS_EN
module gf_mul_serial #(
    parameter int         M     = 6,
    parameter logic [M:0] POLY  = 7'b1000011,
    parameter int         DIGIT = 1
) (
    input  logic            clk,
    input  logic            resetN,
    gf_mul_serial_if.slave  bus
);

    localparam int N  = M / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject parameter sets that cannot describe a valid field or digit split
    generate
        if (M < 2) begin : g_bad_m
            $error("gf_mul_serial: M must be at least 2");
        end
        if ((M % DIGIT) != 0) begin : g_bad_digit
            $error("gf_mul_serial: DIGIT must divide M");
        end
        if (POLY[M] != 1'b1) begin : g_bad_poly
            $error("gf_mul_serial: POLY[M] must be 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [M-1:0]  xr;
    logic [M-1:0]  yr;
    logic [M-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [M-1:0]  z_r;
    logic          busy_r;
    logic          done_r;

    logic [M-1:0]  acc_step;
    logic [M-1:0]  yr_step;

    // Multiply a field element by alpha: shift up and fold x^M back via POLY
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY[M-1:0] : '0);
    endfunction

    // DIGIT Horner steps for one clock, consuming y bits from the top
    always_comb begin
        acc_step = acc;
        yr_step  = yr;
        for (int i = 0; i < DIGIT; i++) begin
            acc_step = mul_alpha(acc_step) ^ (yr_step[M-1] ? xr : '0);
            yr_step  = yr_step << 1;
        end
    end

    // Control FSM and datapath registers; done is a single-cycle pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state  <= IDLE;
            xr     <= '0;
            yr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            z_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
`ifdef GF_MUL_ZERO_BYPASS_EN
                        if ((bus.x == '0) || (bus.y == '0)) begin
                            z_r    <= '0;
                            done_r <= 1'b1;
                        end else begin
                            xr     <= bus.x;
                            yr     <= bus.y;
                            acc    <= '0;
                            cnt    <= '0;
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end
`else
                        xr     <= bus.x;
                        yr     <= bus.y;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    yr  <= yr_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        z_r    <= acc_step;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.z    = z_r;

endmodule

// File: tb/tb_gf_mul_serial.sv
// tb/tb_gf_mul_serial.sv - scoreboard bench for gf_mul_serial at DIGIT 1, 2 and 3
module tb_gf_mul_serial;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    gf_mul_serial_if #(.M(6)) if1 ();
    gf_mul_serial_if #(.M(6)) if2 ();
    gf_mul_serial_if #(.M(6)) if3 ();

    gf_mul_serial #(.M(6), .POLY(7'b1000011), .DIGIT(1)) dut1 (.clk(clk), .resetN(resetN), .bus(if1));
    gf_mul_serial #(.M(6), .POLY(7'b1000011), .DIGIT(2)) dut2 (.clk(clk), .resetN(resetN), .bus(if2));
    gf_mul_serial #(.M(6), .POLY(7'b1000011), .DIGIT(3)) dut3 (.clk(clk), .resetN(resetN), .bus(if3));

    typedef struct {
        logic [5:0] z;
        longint     t;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t e1, e2, e3;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_time(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: done seen at %0d, expected at %0d", name, act, req);
        end
    endtask

    task automatic unexpected_done(input string name, input logic [5:0] zv);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected done with z=%0d, expected no done at %0t", name, zv, $time);
    endtask

    // Reference: schoolbook carry-less product then long division by the polynomial
    function automatic logic [5:0] gf_model(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        logic [10:0] pl;
        p  = '0;
        pl = 11'b000_0100_0011;
        for (int i = 0; i < 6; i++)
            if (b[i]) p = p ^ (11'(a) << i);
        for (int i = 10; i >= 6; i--)
            if (p[i]) p = p ^ (pl << (i - 6));
        return p[5:0];
    endfunction

    // Negedges from the issuing negedge to the one that samples done
    function automatic int lat_of(input int n, input logic [5:0] xv, input logic [5:0] yv);
`ifdef GF_MUL_ZERO_BYPASS_EN
        if ((xv == 6'd0) || (yv == 6'd0)) return 1;
`endif
        return n + 1;
    endfunction

    // Drive start for one cycle from the current negedge; optionally queue the expected result
    task automatic issue(input int sel, input logic [5:0] xv, input logic [5:0] yv,
                         input logic [5:0] ez, input bit track, input int lat);
        exp_t e;
        e.z = ez;
        e.t = longint'($time) + 10 * lat;
        case (sel)
            1: begin if1.start = 1'b1; if1.x = xv; if1.y = yv; if (track) q1.push_back(e); end
            2: begin if2.start = 1'b1; if2.x = xv; if2.y = yv; if (track) q2.push_back(e); end
            default: begin if3.start = 1'b1; if3.x = xv; if3.y = yv; if (track) q3.push_back(e); end
        endcase
        @(negedge clk);
        if1.start = 1'b0;
        if2.start = 1'b0;
        if3.start = 1'b0;
    endtask

    // Monitors: pop the scoreboard whenever a DUT reports a result
    always @(negedge clk) begin
        if (if1.done === 1'b1) begin
            if (q1.size() == 0) unexpected_done("d1", if1.z);
            else begin
                e1 = q1.pop_front();
                check("d1 z", if1.z, e1.z);
                check_time("d1 latency", longint'($time), e1.t);
            end
        end
    end

    always @(negedge clk) begin
        if (if2.done === 1'b1) begin
            if (q2.size() == 0) unexpected_done("d2", if2.z);
            else begin
                e2 = q2.pop_front();
                check("d2 z", if2.z, e2.z);
                check_time("d2 latency", longint'($time), e2.t);
            end
        end
    end

    always @(negedge clk) begin
        if (if3.done === 1'b1) begin
            if (q3.size() == 0) unexpected_done("d3", if3.z);
            else begin
                e3 = q3.pop_front();
                check("d3 z", if3.z, e3.z);
                check_time("d3 latency", longint'($time), e3.t);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        if1.start = 1'b0; if1.x = '0; if1.y = '0;
        if2.start = 1'b0; if2.x = '0; if2.y = '0;
        if3.start = 1'b0; if3.x = '0; if3.y = '0;
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {5'd0, if1.busy}, 6'd0);
        check("reset done", {5'd0, if1.done}, 6'd0);
        check("reset z", if1.z, 6'd0);
        resetN = 1'b1;
        @(negedge clk);

        // alpha * alpha^5 = alpha^6 = alpha + 1; busy for exactly 6 sampled cycles
        issue(1, 6'd2, 6'd32, 6'd3, 1'b1, lat_of(6, 6'd2, 6'd32));
        for (int i = 0; i < 6; i++) begin
            check("busy during run", {5'd0, if1.busy}, 6'd1);
            @(negedge clk);
        end
        check("busy after done", {5'd0, if1.busy}, 6'd0);
        check("done pulse", {5'd0, if1.done}, 6'd1);

        // Back-to-back, each start in the previous done cycle
        issue(1, 6'd32, 6'd32, 6'd48, 1'b1, lat_of(6, 6'd32, 6'd32));
        repeat (6) @(negedge clk);
        issue(1, 6'd3, 6'd3, 6'd5, 1'b1, lat_of(6, 6'd3, 6'd3));
        repeat (6) @(negedge clk);
        issue(1, 6'd1, 6'd37, 6'd37, 1'b1, lat_of(6, 6'd1, 6'd37));
        repeat (6) @(negedge clk);
        repeat (2) @(negedge clk);

        // A start while busy must be ignored
        issue(1, 6'd2, 6'd32, 6'd3, 1'b1, lat_of(6, 6'd2, 6'd32));
        repeat (2) @(negedge clk);
        if1.start = 1'b1; if1.x = 6'd5; if1.y = 6'd7;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (5) @(negedge clk);
        check("z after ignored start", if1.z, 6'd3);

        // Abort mid-operation with reset; no done may follow
        issue(1, 6'd2, 6'd32, 6'd0, 1'b0, 7);
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        #1;
        check("abort busy", {5'd0, if1.busy}, 6'd0);
        check("abort done", {5'd0, if1.done}, 6'd0);
        check("abort z", if1.z, 6'd0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (10) @(negedge clk);
        issue(1, 6'd2, 6'd2, 6'd4, 1'b1, lat_of(6, 6'd2, 6'd2));
        repeat (8) @(negedge clk);

        // Zero operand
        issue(1, 6'd0, 6'd45, 6'd0, 1'b1, lat_of(6, 6'd0, 6'd45));
`ifdef GF_MUL_ZERO_BYPASS_EN
        check("zero busy", {5'd0, if1.busy}, 6'd0);
`else
        check("zero busy", {5'd0, if1.busy}, 6'd1);
`endif
        repeat (7) @(negedge clk);

        // Wider digits
        issue(2, 6'd32, 6'd32, 6'd48, 1'b1, lat_of(3, 6'd32, 6'd32));
        issue(3, 6'd32, 6'd32, 6'd48, 1'b1, lat_of(2, 6'd32, 6'd32));
        repeat (6) @(negedge clk);

        // Exhaustive sweep on the DIGIT=3 instance
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                issue(3, 6'(a), 6'(b), gf_model(6'(a), 6'(b)), 1'b1, lat_of(2, 6'(a), 6'(b)));
                repeat (2) @(negedge clk);
            end
        end
        repeat (10) @(negedge clk);

        check("d1 queue drained", 6'(q1.size()), 6'd0);
        check("d2 queue drained", 6'(q2.size()), 6'd0);
        check("d3 queue drained", 6'(q3.size()), 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
